addsub_pipe: RTL and testbench
==============================

// Module: addsub_pipe
// PURPOSE
//  Parametrised, pipelined successor of the 8-bit add/sub datapath for the ALU.
//  Splits the WIDTH-bit carry chain into STAGES registered segments and adds four
//  operations: add, sub, add-with-carry, sub-with-borrow. Produces status flags.
//  Uses a valid/ready handshake so the ALU result path can apply backpressure.
// PARAMETERS
//  WIDTH   8  operand/result width in bits; WIDTH >= 2
//  STAGES  2  pipeline segments = latency in cycles; 1 <= STAGES <= WIDTH, WIDTH % STAGES == 0
// PORTS
//  clk        in   1      single clock, all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand beat present
//  in_ready   out  1      block can accept a beat this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      carry-in (ADC) / borrow-in (SBB); ignored for ADD/SUB
//  in_op      in   2      00 ADD, 01 SUB, 10 ADC, 11 SBB
//  out_valid  out  1      result beat present
//  out_ready  in   1      downstream accepts result
//  out_sum    out  WIDTH  result
//  out_cout   out  1      carry out; for SUB/SBB 1 = no borrow (A >= B + bin unsigned)
//  out_ovf    out  1      signed overflow (two's complement)
//  out_zero   out  1      out_sum == 0
//  out_neg    out  1      out_sum[WIDTH-1]
// BEHAVIOUR
//  - Arithmetic: ADD A+B+0; SUB A+~B+1; ADC A+B+cin; SBB A+~B+~cin (= A-B-cin).
//    Full WIDTH+1-bit result; out_sum = low WIDTH bits, out_cout = bit WIDTH, wraps mod 2^WIDTH.
//  - ovf = (a_msb == b'_msb) && (sum_msb != a_msb), where b' = B or ~B as applied.
//  - Segment s (SEG = WIDTH/STAGES bits) adds bits [s*SEG +: SEG] using carry from segment s-1.
//    Segment s-1's result is registered before segment s sees it.
//    Upper operand slices are skew-delayed; lower sum slices are de-skew-delayed.
//  - Latency: a beat accepted in cycle n (in_valid & in_ready) appears on out_* in cycle n+STAGES
//    when no stall occurs. Throughput is 1 beat/cycle.
//  - Stall: advance = !out_valid | out_ready; in_ready = advance & !rst.
//    On !advance every pipeline register holds, including bubbles. Bubbles do not collapse.
//  - out_* are stable while out_valid & !out_ready. A beat is never dropped or duplicated.
//  - Flags are computed in the final stage from the registered full sum.
//  - Reset (rst=1 at an edge): all stage valid bits cleared; out_valid=0; out_sum=0.
//    All flags are 0, including out_zero, because they are registered.
//    in_ready=0 while rst=1 and 1 in the cycle after rst deasserts.
//    In-flight beats are discarded. in_valid is ignored during reset.
//  - Simultaneous in_valid & in_ready with out_valid & out_ready: both transfers occur in the same cycle.
// STRUCTURE
//  - addsub_pkg: OP_ADD/OP_SUB/OP_ADC/OP_SBB encodings (2-bit localparams) and function
//    op_invert_b(op), op_carry0(op, cin) returning the B-invert and segment-0 carry.
//  - Sub-module addsub_seg #(SEG): combinational SEG-bit slice add (a, b', ci -> s, co, msb info).
//    It is instantiated STAGES times inside a generate loop. Pipeline registers and the
//    handshake live in addsub_pipe.
// TESTING (WIDTH=8, STAGES=2 unless noted; check latency = 2 and flags on every beat)
//  1 ADD 0x05+0x0A -> sum 0x0F, cout 0, ovf 0, zero 0, neg 0, out_valid in cycle n+2.
//  2 ADC 0x7F+0x00 cin=1 -> 0x80, ovf 1, neg 1.
//    SUB 0x04-0x04 -> 0x00, cout 1, zero 1.
//  3 SBB 0x00-0x00 cin=1 -> 0xFF, cout 0 (borrow), neg 1.
//    SUB 0x80-0x01 -> 0x7F, ovf 1.
//  4 Streaming: 16 back-to-back random beats with out_ready held low for cycles 3-6.
//    Expected: in_ready low during the stall, outputs held stable, all 16 results in order,
//    all matching a reference model.
//  5 Assert rst with 2 beats in flight -> out_valid 0 next cycle, no stale beat emerges afterwards.
//    A beat issued right after reset returns correctly.
//  6 Re-run scenarios 1-4 with WIDTH=16, STAGES=4 and STAGES=1.
//    Check 0xFFFF+0x0001 -> 0x0000 with cout 1 and zero 1.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/sub datapath.
//   OP_ADD / OP_SUB / OP_ADC / OP_SBB : 2-bit operation encodings on in_op.
//   op_invert_b(op)    : 1 when operand B enters the adder inverted (SUB, SBB).
//   op_carry0(op, cin) : carry fed into the lowest segment.
package addsub_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBB = 2'b11;

    function automatic logic op_invert_b(input logic [1:0] op);
        logic inv_s;
        case (op)
            OP_ADD:  inv_s = 1'b0;
            OP_SUB:  inv_s = 1'b1;
            OP_ADC:  inv_s = 1'b0;
            OP_SBB:  inv_s = 1'b1;
            default: inv_s = 1'b0;
        endcase
        return inv_s;
    endfunction

    // SBB computes A + ~B + ~bin, so the borrow-in enters inverted.
    function automatic logic op_carry0(input logic [1:0] op, input logic cin);
        logic c0_s;
        case (op)
            OP_ADD:  c0_s = 1'b0;
            OP_SUB:  c0_s = 1'b1;
            OP_ADC:  c0_s = cin;
            OP_SBB:  c0_s = ~cin;
            default: c0_s = 1'b0;
        endcase
        return c0_s;
    endfunction

endpackage

// File: rtl/addsub_seg.sv
// Combinational SEG-bit slice of the carry chain.
//   a, b : operand slices (b already inverted for subtraction)
//   ci   : carry into the slice
//   s    : slice sum
//   co   : carry out of the slice
//   ovf  : signed overflow judged at this slice's MSB; only meaningful for the
//          topmost slice of the word
module addsub_seg #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           ovf
);

    logic [SEG:0] full_s;

    // Slice add with carry, plus MSB-based overflow detection.
    always_comb begin
        full_s = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
        s      = full_s[SEG-1:0];
        co     = full_s[SEG];
        ovf    = (a[SEG-1] == b[SEG-1]) && (full_s[SEG-1] != a[SEG-1]);
    end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit add/sub/adc/sbb with valid/ready handshake.
// The carry chain is cut into STAGES segments of SEG bits; segment s works on
// bits [s*SEG +: SEG] one cycle after segment s-1, so latency is STAGES cycles.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : operand handshake
//   in_a, in_b            : operands
//   in_cin                : carry-in (ADC) / borrow-in (SBB)
//   in_op                 : 00 ADD, 01 SUB, 10 ADC, 11 SBB
//   out_valid/out_ready   : result handshake
//   out_sum, out_cout     : result and carry (for SUB/SBB, 1 = no borrow)
//   out_ovf, out_zero, out_neg : signed overflow, zero, negative flags
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);

    localparam int SEG = WIDTH / STAGES;

    // Register index k holds a beat after segments 0..k have been computed.
    // opa/opb hold the still-unconsumed operand slices, shifted so that the
    // next slice to add always sits in the low SEG bits (skew delay).
    // sum accumulates the finished low slices in place (de-skew delay).
    logic             vld_q [STAGES];
    logic             vld_d [STAGES];
    logic [WIDTH-1:0] opa_q [STAGES];
    logic [WIDTH-1:0] opa_d [STAGES];
    logic [WIDTH-1:0] opb_q [STAGES];
    logic [WIDTH-1:0] opb_d [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic [WIDTH-1:0] sum_d [STAGES];
    logic             cry_q [STAGES];
    logic             cry_d [STAGES];
    logic             ovf_q;
    logic             ovf_d;
    logic             zero_q;
    logic             zero_d;
    logic             neg_q;
    logic             neg_d;

    logic [SEG-1:0]   seg_a_s   [STAGES];
    logic [SEG-1:0]   seg_b_s   [STAGES];
    logic             seg_ci_s  [STAGES];
    logic [SEG-1:0]   seg_s_s   [STAGES];
    logic             seg_co_s  [STAGES];
    logic             seg_ovf_s [STAGES];
    logic [WIDTH-1:0] in_bp_s;
    logic             advance_s;

    // Whole pipeline moves unless a result is waiting on a stalled consumer.
    always_comb begin
        advance_s = !vld_q[STAGES-1] || out_ready;
        in_ready  = advance_s && !rst;
    end

    // Segment inputs: segment 0 straight from the ports, later ones from the
    // previous register stage.
    always_comb begin
        in_bp_s     = in_b ^ {WIDTH{op_invert_b(in_op)}};
        seg_a_s[0]  = in_a[SEG-1:0];
        seg_b_s[0]  = in_bp_s[SEG-1:0];
        seg_ci_s[0] = op_carry0(in_op, in_cin);
        for (int s = 1; s < STAGES; s++) begin
            seg_a_s[s]  = opa_q[s-1][SEG-1:0];
            seg_b_s[s]  = opb_q[s-1][SEG-1:0];
            seg_ci_s[s] = cry_q[s-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_seg
        addsub_seg #(.SEG(SEG)) u_seg (
            .a   (seg_a_s[g]),
            .b   (seg_b_s[g]),
            .ci  (seg_ci_s[g]),
            .s   (seg_s_s[g]),
            .co  (seg_co_s[g]),
            .ovf (seg_ovf_s[g])
        );
    end

    // Next-state of every stage; flags come from the completed word entering
    // the final register so they are available registered with the sum.
    always_comb begin
        vld_d[0]            = in_valid;
        opa_d[0]            = in_a >> SEG;
        opb_d[0]            = in_bp_s >> SEG;
        sum_d[0]            = {WIDTH{1'b0}};
        sum_d[0][SEG-1:0]   = seg_s_s[0];
        cry_d[0]            = seg_co_s[0];
        for (int s = 1; s < STAGES; s++) begin
            vld_d[s]              = vld_q[s-1];
            opa_d[s]              = opa_q[s-1] >> SEG;
            opb_d[s]              = opb_q[s-1] >> SEG;
            sum_d[s]              = sum_q[s-1];
            sum_d[s][s*SEG +: SEG] = seg_s_s[s];
            cry_d[s]              = seg_co_s[s];
        end
        ovf_d  = seg_ovf_s[STAGES-1];
        zero_d = (sum_d[STAGES-1] == {WIDTH{1'b0}});
        neg_d  = sum_d[STAGES-1][WIDTH-1];
    end

    // Pipeline registers: cleared on reset, frozen (bubbles included) on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                vld_q[s] <= 1'b0;
                opa_q[s] <= {WIDTH{1'b0}};
                opb_q[s] <= {WIDTH{1'b0}};
                sum_q[s] <= {WIDTH{1'b0}};
                cry_q[s] <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (advance_s) begin
            for (int s = 0; s < STAGES; s++) begin
                vld_q[s] <= vld_d[s];
                opa_q[s] <= opa_d[s];
                opb_q[s] <= opb_d[s];
                sum_q[s] <= sum_d[s];
                cry_q[s] <= cry_d[s];
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            neg_q  <= neg_d;
        end
    end

    // Result port mapping from the final stage.
    always_comb begin
        out_valid = vld_q[STAGES-1];
        out_sum   = sum_q[STAGES-1];
        out_cout  = cry_q[STAGES-1];
        out_ovf   = ovf_q;
        out_zero  = zero_q;
        out_neg   = neg_q;
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe. Three instances (8/2, 16/4, 16/1) share
// the clock, reset and out_ready; only the selected one receives beats.
// Every cycle each instance is compared against a reference model built from
// plain integer arithmetic and a queue of in-flight beats that count down the
// number of pipeline advances they still need.
module tb_addsub_pipe;
    import addsub_pkg::*;

    localparam int NDUT = 3;

    typedef struct {
        int          dut;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [1:0]  op;
        int          rem;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] drv_a;
    logic [15:0] drv_b;
    logic        drv_cin;
    logic [1:0]  drv_op;
    logic        drv_valid;
    logic        out_ready;
    int          sel;
    bit          mon_on = 1'b0;

    logic        iv   [NDUT];
    logic        ir   [NDUT];
    logic        ov   [NDUT];
    logic        oc   [NDUT];
    logic        oo   [NDUT];
    logic        oz   [NDUT];
    logic        oneg [NDUT];
    logic [7:0]  s0;
    logic [15:0] s1;
    logic [15:0] s2;

    beat_t sb[$];
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NDUT; k++) iv[k] = drv_valid && (sel == k);
    end

    addsub_pipe #(.WIDTH(8), .STAGES(2)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_a(drv_a[7:0]), .in_b(drv_b[7:0]), .in_cin(drv_cin), .in_op(drv_op),
        .out_valid(ov[0]), .out_ready(out_ready), .out_sum(s0), .out_cout(oc[0]),
        .out_ovf(oo[0]), .out_zero(oz[0]), .out_neg(oneg[0]));

    addsub_pipe #(.WIDTH(16), .STAGES(4)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_a(drv_a), .in_b(drv_b), .in_cin(drv_cin), .in_op(drv_op),
        .out_valid(ov[1]), .out_ready(out_ready), .out_sum(s1), .out_cout(oc[1]),
        .out_ovf(oo[1]), .out_zero(oz[1]), .out_neg(oneg[1]));

    addsub_pipe #(.WIDTH(16), .STAGES(1)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_a(drv_a), .in_b(drv_b), .in_cin(drv_cin), .in_op(drv_op),
        .out_valid(ov[2]), .out_ready(out_ready), .out_sum(s2), .out_cout(oc[2]),
        .out_ovf(oo[2]), .out_zero(oz[2]), .out_neg(oneg[2]));

    function automatic int w_of(input int k);
        return (k == 0) ? 8 : 16;
    endfunction

    function automatic int st_of(input int k);
        case (k)
            0:       return 2;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic [15:0] get_sum(input int k);
        case (k)
            0:       return {8'h00, s0};
            1:       return s1;
            default: return s2;
        endcase
    endfunction

    // Reference: exact unsigned result and exact signed result, then derive
    // wrap-around sum, carry/no-borrow and signed-range overflow.
    function automatic void ref_calc(input int w, input beat_t bt,
                                     output logic [15:0] sum, output logic cout,
                                     output logic ovf);
        longint m, half, ua, ub, sa, sbv, c, full, sres, res;
        m    = 64'sd1 <<< w;
        half = m / 2;
        ua   = longint'({48'd0, bt.a}) & (m - 1);
        ub   = longint'({48'd0, bt.b}) & (m - 1);
        sa   = (ua >= half) ? ua - m : ua;
        sbv  = (ub >= half) ? ub - m : ub;
        c    = bt.cin ? 64'sd1 : 64'sd0;
        case (bt.op)
            2'b00:   begin full = ua + ub;         sres = sa + sbv;     end
            2'b01:   begin full = ua - ub + m;     sres = sa - sbv;     end
            2'b10:   begin full = ua + ub + c;     sres = sa + sbv + c; end
            default: begin full = ua - ub - c + m; sres = sa - sbv - c; end
        endcase
        res  = full % m;
        sum  = res[15:0];
        cout = (full >= m);
        ovf  = (sres < -half) || (sres > half - 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle comparison and model update for the edge that follows.
    always @(negedge clk) begin : monitor
        int          h;
        bit          exp_ov;
        bit          adv;
        logic [15:0] es;
        logic        ec;
        logic        eo;
        beat_t       nb;
        if (mon_on) begin
            for (int k = 0; k < NDUT; k++) begin
                h = -1;
                for (int i = 0; i < sb.size(); i++) if (h < 0 && sb[i].dut == k) h = i;
                exp_ov = 1'b0;
                if (h >= 0) exp_ov = (sb[h].rem == 0);
                adv = !exp_ov || out_ready;
                chk($sformatf("d%0d in_ready", k), ir[k], adv && !rst);
                chk($sformatf("d%0d out_valid", k), ov[k], exp_ov);
                if (exp_ov) begin
                    ref_calc(w_of(k), sb[h], es, ec, eo);
                    chk($sformatf("d%0d sum", k), get_sum(k), es);
                    chk($sformatf("d%0d cout", k), oc[k], ec);
                    chk($sformatf("d%0d ovf", k), oo[k], eo);
                    chk($sformatf("d%0d zero", k), oz[k], es == 16'h0000);
                    chk($sformatf("d%0d neg", k), oneg[k], es[w_of(k)-1]);
                end
                if (rst) begin
                    for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].dut == k) sb.delete(i);
                end else if (adv) begin
                    if (exp_ov) sb.delete(h);
                    foreach (sb[i]) if (sb[i].dut == k && sb[i].rem > 0) sb[i].rem--;
                    if (iv[k]) begin
                        nb.dut = k; nb.a = drv_a; nb.b = drv_b;
                        nb.cin = drv_cin; nb.op = drv_op; nb.rem = st_of(k) - 1;
                        sb.push_back(nb);
                    end
                end
            end
        end
    end

    // Present one beat to the selected instance and hold it until accepted.
    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [1:0] op);
        int guard;
        guard     = 0;
        drv_a     = a;
        drv_b     = b;
        drv_cin   = cin;
        drv_op    = op;
        drv_valid = 1'b1;
        #1;
        while (ir[sel] !== 1'b1 && guard < 50) begin
            @(posedge clk); #2;
            guard++;
        end
        chk("send accepted", ir[sel], 1'b1);
        @(posedge clk); #1;
        drv_valid = 1'b0;
    endtask

    // One beat into an idle pipe; result must appear exactly STAGES cycles later.
    task automatic directed(input logic [15:0] a, input logic [15:0] b, input logic cin,
                            input logic [1:0] op, input logic [15:0] es, input logic ec,
                            input logic eo, input logic ez, input logic en);
        send(a, b, cin, op);
        repeat (st_of(sel) - 1) @(posedge clk);
        @(negedge clk);
        chk("dir out_valid", ov[sel], 1'b1);
        chk("dir sum", get_sum(sel), es);
        chk("dir cout", oc[sel], ec);
        chk("dir ovf", oo[sel], eo);
        chk("dir zero", oz[sel], ez);
        chk("dir neg", oneg[sel], en);
        @(posedge clk); #1;
    endtask

    task automatic run_dir_set();
        logic [15:0] mask;
        logic [15:0] msb;
        mask = (w_of(sel) == 8) ? 16'h00FF : 16'hFFFF;
        msb  = (w_of(sel) == 8) ? 16'h0080 : 16'h8000;
        out_ready = 1'b1;
        directed(16'h0005, 16'h000A, 1'b0, OP_ADD, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);
        directed(msb - 16'h0001, 16'h0000, 1'b1, OP_ADC, msb, 1'b0, 1'b1, 1'b0, 1'b1);
        directed(16'h0004, 16'h0004, 1'b0, OP_SUB, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        directed(16'h0000, 16'h0000, 1'b1, OP_SBB, mask, 1'b0, 1'b0, 1'b0, 1'b1);
        directed(msb, 16'h0001, 1'b0, OP_SUB, msb - 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0);
        directed(mask, 16'h0001, 1'b0, OP_ADD, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    // Back-to-back random beats with the consumer stalled in cycles 3..6.
    task automatic stream(input int n);
        fork
            begin
                for (int i = 0; i < n; i++)
                    send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                         2'($urandom_range(0, 3)));
            end
            begin
                out_ready = 1'b1;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        drv_valid = 1'b0;
        drv_a     = 16'h0000;
        drv_b     = 16'h0000;
        drv_cin   = 1'b0;
        drv_op    = 2'b00;
        out_ready = 1'b1;
        sel       = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_on = 1'b1;

        // Reset state of every instance.
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            chk("rst out_valid", ov[k], 1'b0);
            chk("rst sum", get_sum(k), 16'h0000);
            chk("rst flags", {oc[k], oo[k], oz[k], oneg[k]}, 4'b0000);
            chk("rst in_ready", ir[k], 1'b1);
        end
        @(posedge clk); #1;

        sel = 0;
        run_dir_set();
        stream(16);

        // Reset with two beats in flight while the consumer stalls.
        out_ready = 1'b0;
        send(16'h0011, 16'h0022, 1'b0, OP_ADD);
        send(16'h0033, 16'h0001, 1'b0, OP_SUB);
        rst       = 1'b1;
        drv_valid = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        drv_valid = 1'b0;
        @(negedge clk);
        chk("post-rst out_valid", ov[0], 1'b0);
        chk("post-rst sum", get_sum(0), 16'h0000);
        chk("post-rst flags", {oc[0], oo[0], oz[0], oneg[0]}, 4'b0000);
        chk("post-rst in_ready", ir[0], 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        directed(16'h0005, 16'h000A, 1'b0, OP_ADD, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);

        sel = 1;
        run_dir_set();
        stream(16);

        sel = 2;
        run_dir_set();
        stream(16);

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
